// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute stage and the ALU decoder:
//   - ALUOp codes (ALU_ADD .. ALU_DIV, ALU_NA)
//   - FSM state encoding of the sequential execute stage
//   - is_iter_op(): tells whether an op runs on the iterative datapath
// Optional feature macro: ALU_SEQ_DIV_EN (DIV is iterative when defined,
// otherwise DIV is handled like NA).
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_XOR = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_LST = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;
  localparam logic [3:0] ALU_DIV = 4'd9;
  localparam logic [3:0] ALU_NA  = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // True for ops that use the 1-bit-per-cycle multiply/divide datapath.
  function automatic logic is_iter_op(input logic [3:0] op);
    logic iter_v;
    iter_v = 1'b0;
    case (op)
      ALU_MUL: iter_v = 1'b1;
`ifdef ALU_SEQ_DIV_EN
      ALU_DIV: iter_v = 1'b1;
`endif
      default: iter_v = 1'b0;
    endcase
    return iter_v;
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// ---------------------------------------------------------------------------
// alu_iter_muldiv
// Iterative multiply / restoring divide datapath, one bit per iteration.
//   MUL: sr = multiplier (shifts right), opnd = multiplicand (shifts left),
//        acc accumulates the low WIDTH bits of the product.
//   DIV: sr = dividend, shifted left and refilled with quotient bits,
//        opnd = divisor, acc = partial remainder.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   load_i      latch operands, clear accumulator/remainder, capture mode
//   iter_i      perform one iteration
//   div_i       mode at load: 1 = divide, 0 = multiply
//   a_i, b_i    operands A and B
//   result_o    value the result takes after the current iteration; the
//               caller samples it on the final iterate cycle
// Optional feature macro: ALU_SEQ_DIV_EN (divider logic only when defined).
// ---------------------------------------------------------------------------
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             iter_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o
);

  logic [WIDTH-1:0] sr_q,   sr_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_q,  acc_d;

`ifdef ALU_SEQ_DIV_EN
  logic             mode_div_q, mode_div_d;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH:0]   diff_s;

  // Next-state of the shared datapath for load, multiply or divide step.
  always_comb begin
    sr_d       = sr_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    mode_div_d = mode_div_q;
    rem_sh_s   = {acc_q, sr_q[WIDTH-1]};
    diff_s     = rem_sh_s - {1'b0, opnd_q};
    if (load_i) begin
      mode_div_d = div_i;
      sr_d       = div_i ? a_i : b_i;
      opnd_d     = div_i ? b_i : a_i;
      acc_d      = {WIDTH{1'b0}};
    end else if (iter_i) begin
      if (mode_div_q) begin
        // Restoring step: keep the difference only if it did not go negative.
        // A zero divisor always succeeds, giving an all-ones quotient.
        if (!diff_s[WIDTH]) begin
          acc_d = diff_s[WIDTH-1:0];
          sr_d  = {sr_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_sh_s[WIDTH-1:0];
          sr_d  = {sr_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d  = acc_q + (sr_q[0] ? opnd_q : {WIDTH{1'b0}});
        sr_d   = sr_q >> 1;
        opnd_d = opnd_q << 1;
      end
    end else begin
      sr_d = sr_q;
    end
  end

  // Quotient lives in the shift register, product in the accumulator.
  always_comb begin
    if (mode_div_q) begin
      result_o = sr_d;
    end else begin
      result_o = acc_d;
    end
  end

  // Mode register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_div_q <= 1'b0;
    end else begin
      mode_div_q <= mode_div_d;
    end
  end
`else
  logic unused_div_s;
  assign unused_div_s = div_i;

  // Next-state of the multiply-only datapath.
  always_comb begin
    sr_d   = sr_q;
    opnd_d = opnd_q;
    acc_d  = acc_q;
    if (load_i) begin
      sr_d   = b_i;
      opnd_d = a_i;
      acc_d  = {WIDTH{1'b0}};
    end else if (iter_i) begin
      acc_d  = acc_q + (sr_q[0] ? opnd_q : {WIDTH{1'b0}});
      sr_d   = sr_q >> 1;
      opnd_d = opnd_q << 1;
    end else begin
      acc_d = acc_q;
    end
  end

  assign result_o = acc_d;
`endif

  // Operand, shift and accumulator registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q   <= {WIDTH{1'b0}};
      opnd_q <= {WIDTH{1'b0}};
      acc_q  <= {WIDTH{1'b0}};
    end else begin
      sr_q   <= sr_d;
      opnd_q <= opnd_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/alu_seq_exec.sv
// ---------------------------------------------------------------------------
// alu_seq_exec
// Execute stage behind the ALU decoder. Simple ops finish in one cycle,
// MUL (and DIV when enabled) run WIDTH iterations on alu_iter_muldiv.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   start       op request, only looked at in IDLE
//   ALUOp       op code (alu_pkg)
//   A, B        operands, latched when the op is accepted
//   busy        op accepted and not yet complete (includes the accept cycle)
//   done        one-cycle pulse, ALUResult valid
//   ALUResult   registered result, held until the next done
//   Zero        registered, ALUResult == 0
// Optional feature macro: ALU_SEQ_DIV_EN (iterative DIV when defined,
// otherwise DIV is a single-cycle op returning 0).
// ---------------------------------------------------------------------------
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int SH_W  = $clog2(WIDTH);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               done_q;
  logic [WIDTH-1:0]   res_q;
  logic               zero_q;

  logic [WIDTH-1:0]   alu_res_d;
  logic [SH_W-1:0]    sh_amt_s;
  logic               lst_s;
  logic               accept_s;
  logic               iter_op_s;
  logic               load_s;
  logic               iter_s;
  logic               last_iter_s;
  logic [WIDTH-1:0]   md_result_s;

  assign sh_amt_s    = B[SH_W-1:0];
  assign lst_s       = ($signed(A) < $signed(B));
  assign accept_s    = (state_q == IDLE) && start;
  assign iter_op_s   = is_iter_op(ALUOp);
  assign load_s      = accept_s && iter_op_s;
  assign iter_s      = (state_q == RUN);
  assign last_iter_s = (cnt_q == CNT_W'(WIDTH - 1));

  // Single-cycle ALU; iterative and unknown codes fall to the zero default.
  always_comb begin
    alu_res_d = {WIDTH{1'b0}};
    case (ALUOp)
      ALU_ADD: alu_res_d = A + B;
      ALU_SUB: alu_res_d = A - B;
      ALU_XOR: alu_res_d = A ^ B;
      ALU_OR:  alu_res_d = A | B;
      ALU_AND: alu_res_d = A & B;
      ALU_SLL: alu_res_d = A << sh_amt_s;
      ALU_SRL: alu_res_d = A >> sh_amt_s;
      ALU_LST: alu_res_d = {{(WIDTH-1){1'b0}}, lst_s};
      default: alu_res_d = {WIDTH{1'b0}};
    endcase
  end

  alu_iter_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load_s),
    .iter_i   (iter_s),
    .div_i    (ALUOp == ALU_DIV),
    .a_i      (A),
    .b_i      (B),
    .result_o (md_result_s)
  );

  // Control FSM with iteration counter and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      done_q  <= 1'b0;
      res_q   <= {WIDTH{1'b0}};
      zero_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (iter_op_s) begin
              cnt_q   <= {CNT_W{1'b0}};
              state_q <= RUN;
            end else begin
              res_q   <= alu_res_d;
              zero_q  <= (alu_res_d == {WIDTH{1'b0}});
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter_s) begin
            res_q   <= md_result_s;
            zero_q  <= (md_result_s == {WIDTH{1'b0}});
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= RUN;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // busy covers the accept cycle, so it must see start directly.
  assign busy      = (state_q == RUN) || accept_s;
  assign done      = done_q;
  assign ALUResult = res_q;
  assign Zero      = zero_q;

endmodule
